// File: rtl/ifu.sv
// -----------------------------------------------------------------------------
// ifu : instruction fetch unit of the single-cycle RISC-V core.
//
// Holds the 32-bit program counter and sign-extends the immediate field of the
// current instruction. The next PC is either sequential (PC+4) or a branch/jump
// target (PC+ImmExt). Both adders wrap modulo 2^32. Target alignment is not
// checked, so an odd target from an I-type immediate is loaded as-is.
//
// Ports:
//   clk_IF     in   1   system clock, PC updates on the rising edge
//   areset_IF  in   1   asynchronous active-high reset, forces PC to 0
//   load_IF    in   1   PC write enable, PC holds when 0
//   PCSrc_IF   in   1   next-PC select: 0 = PC+4, 1 = PC+ImmExt_IF
//   ImmSrc_IF  in   2   immediate format: 00 I, 01 S, 10 B, 11 J
//   Instr      in   25  instruction bits [31:7], indices match the ISA word
//   ImmExt_IF  out  32  sign-extended immediate, purely combinational
//   PC_IF      out  32  current program counter, registered
// -----------------------------------------------------------------------------
module ifu (
   input  logic        clk_IF,
   input  logic        areset_IF,
   input  logic        load_IF,
   input  logic        PCSrc_IF,
   input  logic [1:0]  ImmSrc_IF,
   input  logic [31:7] Instr,
   output logic [31:0] ImmExt_IF,
   output logic [31:0] PC_IF
);

   logic [31:0] r_pc;
   logic [31:0] w_imm_ext;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_pc_target;
   logic [31:0] w_pc_next;

   // Immediate extraction and sign extension for the four formats
   always_comb begin
      w_imm_ext = 32'h0000_0000;
      case (ImmSrc_IF)
         2'b00:   w_imm_ext = {{20{Instr[31]}}, Instr[31:20]};
         2'b01:   w_imm_ext = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
         2'b10:   w_imm_ext = {{20{Instr[31]}}, Instr[7], Instr[30:25],
                               Instr[11:8], 1'b0};
         2'b11:   w_imm_ext = {{12{Instr[31]}}, Instr[19:12], Instr[20],
                               Instr[30:21], 1'b0};
         default: w_imm_ext = 32'h0000_0000;
      endcase
   end

   // Next-PC adders (carry-out dropped, so both wrap) and source select
   always_comb begin
      w_pc_plus4  = r_pc + 32'd4;
      w_pc_target = r_pc + w_imm_ext;
      if (PCSrc_IF) begin
         w_pc_next = w_pc_target;
      end else begin
         w_pc_next = w_pc_plus4;
      end
   end

   // Program counter register; reset wins over any clock edge while high
   always_ff @(posedge clk_IF or posedge areset_IF) begin
      if (areset_IF) begin
         r_pc <= 32'h0000_0000;
      end else if (load_IF) begin
         r_pc <= w_pc_next;
      end else begin
         r_pc <= r_pc;
      end
   end

   assign ImmExt_IF = w_imm_ext;
   assign PC_IF     = r_pc;

endmodule

// File: tb/tb_ifu.sv
// -----------------------------------------------------------------------------
// tb_ifu : directed self-checking bench for ifu.
// Inputs are driven at the falling edge; outputs are sampled 1 time unit after
// the rising edge, or 1 time unit after an input change for combinational
// paths.
// -----------------------------------------------------------------------------
module tb_ifu;

   logic        clk_IF;
   logic        areset_IF;
   logic        load_IF;
   logic        PCSrc_IF;
   logic [1:0]  ImmSrc_IF;
   logic [31:7] Instr;
   logic [31:0] ImmExt_IF;
   logic [31:0] PC_IF;

   int n_pass;
   int n_total;

   ifu dut (
      .clk_IF    (clk_IF),
      .areset_IF (areset_IF),
      .load_IF   (load_IF),
      .PCSrc_IF  (PCSrc_IF),
      .ImmSrc_IF (ImmSrc_IF),
      .Instr     (Instr),
      .ImmExt_IF (ImmExt_IF),
      .PC_IF     (PC_IF)
   );

   initial clk_IF = 1'b0;
   always #5 clk_IF = ~clk_IF;

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk_IF);
      #1;
   endtask

   function automatic logic [31:7] hi(input logic [31:0] w);
      return w[31:7];
   endfunction

   // Expected immediates for 0xFFF00093 under formats I, S, B, J.
   logic [31:0] fmt_exp [4];

   initial begin
      n_pass    = 0;
      n_total   = 0;
      areset_IF = 1'b0;
      load_IF   = 1'b0;
      PCSrc_IF  = 1'b0;
      ImmSrc_IF = 2'd0;
      Instr     = 25'd0;
      fmt_exp[0] = 32'hFFFF_FFFF;
      fmt_exp[1] = 32'hFFFF_FFE1;
      fmt_exp[2] = 32'hFFFF_FFE0;
      fmt_exp[3] = 32'hFFF0_0FFE;

      // Reset asserted between edges clears PC at once
      @(negedge clk_IF);
      areset_IF = 1'b1;
      #1;
      check32("reset_immediate", PC_IF, 32'h0000_0000);
      for (int i = 0; i < 2; i++) begin
         tick();
         check32("reset_hold", PC_IF, 32'h0000_0000);
      end
      // Clock edges ignored under reset even with load high
      @(negedge clk_IF);
      load_IF = 1'b1;
      tick();
      check32("reset_ignores_load", PC_IF, 32'h0000_0000);

      // Sequential fetch
      @(negedge clk_IF);
      areset_IF = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         check32("seq_fetch", PC_IF, 32'(4 * i));
      end

      // Branch taken with B-type offset 10
      @(negedge clk_IF);
      PCSrc_IF  = 1'b1;
      ImmSrc_IF = 2'd2;
      Instr     = 25'd10;
      #1;
      check32("branch_imm", ImmExt_IF, 32'd10);
      tick();
      check32("branch_pc", PC_IF, 32'd50);

      // Immediate formats on 0xFFF00093, PC frozen
      @(negedge clk_IF);
      load_IF = 1'b0;
      Instr   = hi(32'hFFF0_0093);
      for (int k = 0; k < 4; k++) begin
         ImmSrc_IF = k[1:0];
         #1;
         check32("imm_format", ImmExt_IF, fmt_exp[k]);
      end

      // Negative B offset -8
      @(negedge clk_IF);
      load_IF   = 1'b1;
      PCSrc_IF  = 1'b1;
      ImmSrc_IF = 2'd2;
      Instr     = hi(32'hFE00_0C80);
      #1;
      check32("b_neg_imm", ImmExt_IF, 32'hFFFF_FFF8);
      tick();
      check32("b_neg_pc", PC_IF, 32'd42);

      // Negative J offset -8
      @(negedge clk_IF);
      ImmSrc_IF = 2'd3;
      Instr     = hi(32'hFF9F_F000);
      #1;
      check32("j_neg_imm", ImmExt_IF, 32'hFFFF_FFF8);
      tick();
      check32("j_neg_pc", PC_IF, 32'd34);

      // Load gating with PCSrc toggling
      @(negedge clk_IF);
      load_IF = 1'b0;
      for (int i = 0; i < 5; i++) begin
         PCSrc_IF = i[0];
         tick();
         check32("load_gate", PC_IF, 32'd34);
         @(negedge clk_IF);
      end

      // I-type -2 brings PC to 0x20
      load_IF   = 1'b1;
      PCSrc_IF  = 1'b1;
      ImmSrc_IF = 2'd0;
      Instr     = hi(32'hFFE0_0000);
      tick();
      check32("pc_to_20", PC_IF, 32'h0000_0020);

      // Async reset mid-run
      @(negedge clk_IF);
      PCSrc_IF  = 1'b0;
      areset_IF = 1'b1;
      #1;
      check32("midrun_reset", PC_IF, 32'h0000_0000);
      tick();
      check32("midrun_reset_hold", PC_IF, 32'h0000_0000);
      @(negedge clk_IF);
      areset_IF = 1'b0;
      tick();
      check32("restart_fetch", PC_IF, 32'd4);

      // Odd target from I-type +1 is loaded unaligned
      @(negedge clk_IF);
      PCSrc_IF  = 1'b1;
      ImmSrc_IF = 2'd0;
      Instr     = hi(32'h0010_0000);
      tick();
      check32("odd_target", PC_IF, 32'd5);

      // Underflow: 5 + (-9) wraps to 0xFFFFFFFC
      @(negedge clk_IF);
      Instr = hi(32'hFF70_0000);
      tick();
      check32("target_underflow", PC_IF, 32'hFFFF_FFFC);

      // Sequential wrap to 0
      @(negedge clk_IF);
      PCSrc_IF = 1'b0;
      tick();
      check32("seq_wrap", PC_IF, 32'h0000_0000);

      // Branch -8 from 0 wraps
      @(negedge clk_IF);
      PCSrc_IF  = 1'b1;
      ImmSrc_IF = 2'd2;
      Instr     = hi(32'hFE00_0C80);
      tick();
      check32("branch_wrap", PC_IF, 32'hFFFF_FFF8);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
